stage_sum_accumulator: RTL and testbench
========================================

STAGE_SUM_ACCUMULATOR -- requirements
Module: stage_sum_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of all data words, signed two's complement Q16.16.
REQ-002 SHALL have parameter MAX_WEAK, default 256: maximum weak classifiers per stage.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have port stage_start_i  in  1  one-cycle pulse that begins a new stage.
REQ-006 SHALL have port break_i  in  1  abort; discards the current stage.
REQ-007 SHALL have port weak_val_i  in  1  weak-classifier term valid.
REQ-008 SHALL have port weak_ready_o  out  1  term accepted when weak_val_i && weak_ready_o.
REQ-009 SHALL have port weak_last_i  in  1  qualifies the accepted term as the last of the stage.
REQ-010 SHALL have port feature_i  in  DATA_W  feature response, variance-normalised.
REQ-011 SHALL have port node_threshold_i  in  DATA_W  weak-node threshold.
REQ-012 SHALL have port left_val_i / right_val_i  in  DATA_W each  leaf values.
REQ-013 SHALL have port stage_sum_o  out  DATA_W  accumulated stage sum.
REQ-014 SHALL have port stage_sum_val_o  out  1  one-cycle pulse, stage sum final; feeds the downstream stage_sum_val_i.
REQ-015 SHALL have port weak_cnt_o  out  $clog2(MAX_WEAK)+1  terms accepted in the current stage.
REQ-016 SHALL have port error_o  out  1  sticky: stage exceeded MAX_WEAK.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DRAIN.
REQ-018 stage_start_i in any state SHALL, at the next edge, enter ACCUM and clear the accumulator, weak_cnt_o, error_o and the pipeline register.
REQ-019 weak_ready_o SHALL be 1 only in ACCUM; weak_val_i outside ACCUM SHALL be ignored.
REQ-020 Term select: feature_i < node_threshold_i (signed) SHALL give left_val_i; otherwise, including equality, right_val_i.
REQ-021 Pipeline stage 1 SHALL register the selected value and the last flag on the accept edge.
REQ-022 Stage 2 SHALL add the registered value to the accumulator on the following edge.
REQ-023 Back-to-back accepts every cycle SHALL be sustained without bubbles.
REQ-024 Addition SHALL saturate to 0x7FFFFFFF or 0x80000000; there is no wrap-around.
REQ-025 An accept with weak_last_i=1 SHALL move ACCUM to DRAIN.
REQ-026 stage_sum_val_o SHALL be high exactly 2 cycles after the last accept cycle, for 1 cycle; the FSM SHALL then return to IDLE.
REQ-027 stage_sum_o SHALL equal the accumulator and SHALL hold its final value until the next stage_start_i.
REQ-028 The accept that makes weak_cnt_o reach MAX_WEAK with weak_last_i=0 SHALL be treated as last and SHALL set error_o.
REQ-029 break_i SHALL, at the next edge, force IDLE, flush the pipeline and suppress any pending stage_sum_val_o.
REQ-030 break_i and stage_start_i high together: break_i SHALL win.
REQ-031 stage_start_i during DRAIN SHALL abandon the pending sum without a pulse.
REQ-032 weak_last_i on the first accept (single-term stage) SHALL be legal: stage_sum_o = selected value.

Reset
REQ-033 rst_i SHALL give: IDLE, accumulator 0, pipeline invalid, stage_sum_o=0, stage_sum_val_o=0, weak_ready_o=0, weak_cnt_o=0, error_o=0.
REQ-034 Reset asserted mid-stage SHALL discard all state, with no pulse after release.

Structure
REQ-035 Package vj_pkg SHALL hold DATA_W, FRAC_W=16, MAX_WEAK, the saturation constants and the FSM state enum.
REQ-036 Sub-module weak_classifier_select SHALL contain the compare/select and pipeline stage 1; accumulator and FSM stay in the top.

Verification
REQ-037 Start, 3 terms: (f=0x8000, t=0x10000, L=0x10000, R=0x20000), (f=0x30000, t=0x10000, L=0x5000, R=0x8000), (f=t=0x10000, L=1, R=2, last), each on consecutive cycles -> pulse 2 cycles after the last accept, sum 0x18002, weak_cnt_o=3.
REQ-038 Terms R=0x7FFF0000 twice, then a last term 0x00020000 -> sum 0x7FFFFFFF, pulse present.
REQ-039 break_i one cycle after the last accept -> no stage_sum_val_o, IDLE, weak_ready_o=0.
REQ-040 MAX_WEAK=4, four terms of 0x10000 without last -> error_o=1, pulse, sum 0x40000, weak_ready_o drops after the 4th accept.
REQ-041 stage_start_i and break_i together -> IDLE; stage_start_i alone next cycle -> ACCUM, sum 0.
REQ-042 rst_i during ACCUM after 2 terms -> all outputs at reset values, no pulse in the 5 cycles that follow.

Source files
------------

// File: rtl/vj_pkg.sv
// Shared constants and FSM encoding for the cascade stage-sum datapath.
package vj_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned FRAC_W   = 16;
    localparam int unsigned MAX_WEAK = 256;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/weak_classifier_select.sv
// Weak-node compare/select and the first pipeline register of the stage-sum path.
module weak_classifier_select #(
    parameter int unsigned DATA_W = vj_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] feature_i,
    input  logic [DATA_W-1:0] node_threshold_i,
    input  logic [DATA_W-1:0] left_val_i,
    input  logic [DATA_W-1:0] right_val_i,
    output logic [DATA_W-1:0] term_o,
    output logic              term_last_o,
    output logic              term_val_o
);

    logic [DATA_W-1:0] sel_c;

    // Strictly below threshold takes the left leaf; equality goes right.
    assign sel_c = ($signed(feature_i) < $signed(node_threshold_i)) ? left_val_i : right_val_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            term_o      <= '0;
            term_last_o <= 1'b0;
            term_val_o  <= 1'b0;
        end else begin
            term_val_o  <= load_i;
            term_last_o <= load_i && last_i;
            if (load_i) begin
                term_o <= sel_c;
            end
        end
    end

endmodule

// File: rtl/stage_sum_accumulator.sv
// Accumulates selected weak-classifier leaf values into a saturating stage sum.
module stage_sum_accumulator #(
    parameter int unsigned DATA_W   = vj_pkg::DATA_W,
    parameter int unsigned MAX_WEAK = vj_pkg::MAX_WEAK
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       stage_start_i,
    input  logic                       break_i,
    input  logic                       weak_val_i,
    output logic                       weak_ready_o,
    input  logic                       weak_last_i,
    input  logic [DATA_W-1:0]          feature_i,
    input  logic [DATA_W-1:0]          node_threshold_i,
    input  logic [DATA_W-1:0]          left_val_i,
    input  logic [DATA_W-1:0]          right_val_i,
    output logic [DATA_W-1:0]          stage_sum_o,
    output logic                       stage_sum_val_o,
    output logic [$clog2(MAX_WEAK):0]  weak_cnt_o,
    output logic                       error_o
);

    import vj_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_WEAK) + 1;
    localparam logic [DATA_W-1:0] SAT_HI = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_LO = {1'b1, {(DATA_W-1){1'b0}}};

    state_e             state_q;
    state_e             state_d;
    logic [DATA_W-1:0]  acc_q;
    logic [CNT_W-1:0]   weak_cnt_q;
    logic               error_q;
    logic               weak_ready_q;
    logic               sum_val_q;

    logic               accept_c;
    logic               load_c;
    logic               cap_c;
    logic               last_eff_c;
    logic [DATA_W-1:0]  term_q;
    logic               term_last_q;
    logic               term_val_q;
    logic [DATA_W:0]    sum_ext_c;
    logic [DATA_W-1:0]  acc_next_c;

    assign accept_c   = weak_val_i && weak_ready_q;
    assign load_c     = accept_c && !break_i && !stage_start_i;
    // Hitting the term budget without a last flag closes the stage as an error.
    assign cap_c      = (weak_cnt_q == CNT_W'(MAX_WEAK - 1));
    assign last_eff_c = weak_last_i || cap_c;

    weak_classifier_select #(
        .DATA_W (DATA_W)
    ) u_select (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (break_i || stage_start_i),
        .load_i           (load_c),
        .last_i           (last_eff_c),
        .feature_i        (feature_i),
        .node_threshold_i (node_threshold_i),
        .left_val_i       (left_val_i),
        .right_val_i      (right_val_i),
        .term_o           (term_q),
        .term_last_o      (term_last_q),
        .term_val_o       (term_val_q)
    );

    // Saturating add: overflow shows as disagreement of the two top bits.
    assign sum_ext_c = {acc_q[DATA_W-1], acc_q} + {term_q[DATA_W-1], term_q};

    always_comb begin
        acc_next_c = sum_ext_c[DATA_W-1:0];
        if (sum_ext_c[DATA_W] != sum_ext_c[DATA_W-1]) begin
            acc_next_c = sum_ext_c[DATA_W] ? SAT_LO : SAT_HI;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (break_i) begin
            state_d = ST_IDLE;
        end else if (stage_start_i) begin
            state_d = ST_ACCUM;
        end else begin
            case (state_q)
                ST_ACCUM: if (accept_c && last_eff_c) state_d = ST_DRAIN;
                ST_DRAIN: state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q        <= '0;
            weak_cnt_q   <= '0;
            error_q      <= 1'b0;
            weak_ready_q <= 1'b0;
            sum_val_q    <= 1'b0;
        end else begin
            weak_ready_q <= (state_d == ST_ACCUM);
            sum_val_q    <= 1'b0;
            if (stage_start_i && !break_i) begin
                acc_q      <= '0;
                weak_cnt_q <= '0;
                error_q    <= 1'b0;
            end else if (!break_i) begin
                if (load_c) begin
                    weak_cnt_q <= weak_cnt_q + CNT_W'(1);
                    if (cap_c && !weak_last_i) begin
                        error_q <= 1'b1;
                    end
                end
                if (term_val_q) begin
                    acc_q     <= acc_next_c;
                    sum_val_q <= term_last_q;
                end
            end
        end
    end

    assign weak_ready_o    = weak_ready_q;
    assign stage_sum_o     = acc_q;
    assign stage_sum_val_o = sum_val_q;
    assign weak_cnt_o      = weak_cnt_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_stage_sum_accumulator.sv
// Scoreboard bench for stage_sum_accumulator: directed cases plus random stages.
module tb_stage_sum_accumulator;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WEAK = 4;
    localparam int unsigned CNT_W    = $clog2(MAX_WEAK) + 1;

    typedef struct {
        logic [31:0] f;
        logic [31:0] t;
        logic [31:0] l;
        logic [31:0] r;
        bit          last;
    } term_t;

    typedef struct {
        logic [31:0] sum;
        int          cnt;
        bit          err;
        longint      cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              stage_start_i = 1'b0;
    logic              break_i = 1'b0;
    logic              weak_val_i = 1'b0;
    logic              weak_ready_o;
    logic              weak_last_i = 1'b0;
    logic [DATA_W-1:0] feature_i = '0;
    logic [DATA_W-1:0] node_threshold_i = '0;
    logic [DATA_W-1:0] left_val_i = '0;
    logic [DATA_W-1:0] right_val_i = '0;
    logic [DATA_W-1:0] stage_sum_o;
    logic              stage_sum_val_o;
    logic [CNT_W-1:0]  weak_cnt_o;
    logic              error_o;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    stage_sum_accumulator #(
        .DATA_W   (DATA_W),
        .MAX_WEAK (MAX_WEAK)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .stage_start_i    (stage_start_i),
        .break_i          (break_i),
        .weak_val_i       (weak_val_i),
        .weak_ready_o     (weak_ready_o),
        .weak_last_i      (weak_last_i),
        .feature_i        (feature_i),
        .node_threshold_i (node_threshold_i),
        .left_val_i       (left_val_i),
        .right_val_i      (right_val_i),
        .stage_sum_o      (stage_sum_o),
        .stage_sum_val_o  (stage_sum_val_o),
        .weak_cnt_o       (weak_cnt_o),
        .error_o          (error_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: selected leaf of one weak node, Q16.16 signed.
    function automatic longint sel_val(input term_t t);
        if ($signed(t.f) < $signed(t.t)) return longint'($signed(t.l));
        return longint'($signed(t.r));
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic term_t mk(input logic [31:0] f, input logic [31:0] t,
                                 input logic [31:0] l, input logic [31:0] r, input bit last);
        term_t x;
        x.f = f; x.t = t; x.l = l; x.r = r; x.last = last;
        return x;
    endfunction

    function automatic logic [31:0] rand_leaf();
        if ($urandom_range(99) < 30) return $urandom;
        return 32'($urandom_range(32'h0020_0000)) - 32'h0010_0000;
    endfunction

    function automatic term_t rand_term(input bit last);
        term_t x;
        x.f = 32'($urandom_range(32'h0008_0000)) - 32'h0004_0000;
        x.t = ($urandom_range(99) < 15) ? x.f : 32'($urandom_range(32'h0008_0000)) - 32'h0004_0000;
        x.l = rand_leaf();
        x.r = rand_leaf();
        x.last = last;
        return x;
    endfunction

    task automatic drive_term(input term_t t, input bit val);
        feature_i        = t.f;
        node_threshold_i = t.t;
        left_val_i       = t.l;
        right_val_i      = t.r;
        weak_last_i      = t.last;
        weak_val_i       = val;
    endtask

    task automatic start_stage();
        stage_start_i = 1'b1;
        tick();
        stage_start_i = 1'b0;
    endtask

    // Drives terms into a freshly started stage and queues the expected final sum.
    task automatic run_terms(input term_t terms[$], input int gap_pct);
        longint acc  = 0;
        int     k    = 0;
        bit     done = 1'b0;
        exp_t   e;
        foreach (terms[i]) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                drive_term(rand_term(1'b1), 1'b0);
                tick();
            end
            check("weak_ready", longint'(weak_ready_o), done ? 0 : 1);
            drive_term(terms[i], 1'b1);
            if (!done) begin
                acc = clamp(acc + sel_val(terms[i]));
                k++;
                if (terms[i].last || k == int'(MAX_WEAK)) begin
                    done  = 1'b1;
                    e.sum = 32'(acc);
                    e.cnt = k;
                    e.err = !terms[i].last;
                    e.cyc = cyc + 2;
                    exp_q.push_back(e);
                end
            end
            tick();
        end
        weak_val_i  = 1'b0;
        weak_last_i = 1'b0;
        repeat (3) tick();
        if (done) begin
            check("sum_hold", longint'(stage_sum_o), longint'(e.sum));
            check("cnt_hold", longint'(weak_cnt_o), longint'(k));
            check("err_hold", longint'(error_o), longint'(e.err));
            check("ready_idle", longint'(weak_ready_o), 0);
        end
    endtask

    task automatic run_stage(input term_t terms[$], input int gap_pct);
        start_stage();
        run_terms(terms, gap_pct);
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (stage_sum_val_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: stage_sum_val_o=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_sum", longint'(stage_sum_o), longint'(e.sum));
                check("pulse_cnt", longint'(weak_cnt_o), longint'(e.cnt));
                check("pulse_err", longint'(error_o), longint'(e.err));
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_pulse: none by cycle %0d, required at cycle %0d", cyc, e.cyc);
        end
    end

    initial begin
        term_t tq[$];
        int    n;

        repeat (3) tick();
        check("rst_sum", longint'(stage_sum_o), 0);
        check("rst_val", longint'(stage_sum_val_o), 0);
        check("rst_ready", longint'(weak_ready_o), 0);
        check("rst_cnt", longint'(weak_cnt_o), 0);
        check("rst_err", longint'(error_o), 0);
        rst_i = 1'b0;
        tick();

        // Three-term stage with left, right and equality selections.
        tq = {mk(32'h8000, 32'h10000, 32'h10000, 32'h20000, 0),
              mk(32'h30000, 32'h10000, 32'h5000, 32'h8000, 0),
              mk(32'h10000, 32'h10000, 32'h1, 32'h2, 1)};
        run_stage(tq, 0);
        check("sum_3term", longint'(stage_sum_o), 64'h18002);

        // Positive saturation.
        tq = {mk(32'h0, 32'h0, 32'h0, 32'h7FFF0000, 0),
              mk(32'h0, 32'h0, 32'h0, 32'h7FFF0000, 0),
              mk(32'h0, 32'h0, 32'h0, 32'h00020000, 1)};
        run_stage(tq, 0);
        check("sum_sat", longint'(stage_sum_o), 64'h7FFFFFFF);

        // Single-term stage.
        tq = {mk(32'hFFFF0000, 32'h0, 32'hFFFE8000, 32'h5, 1)};
        run_stage(tq, 0);

        // Budget exhausted without last: error, forced pulse, extra term ignored.
        tq = {mk(0, 0, 0, 32'h10000, 0), mk(0, 0, 0, 32'h10000, 0),
              mk(0, 0, 0, 32'h10000, 0), mk(0, 0, 0, 32'h10000, 0),
              mk(0, 0, 0, 32'h10000, 0)};
        run_stage(tq, 0);
        check("sum_cap", longint'(stage_sum_o), 64'h40000);

        // Break one cycle after the last accept suppresses the pulse.
        start_stage();
        drive_term(mk(0, 0, 0, 32'h30000, 0), 1'b1);
        tick();
        drive_term(mk(0, 0, 0, 32'h30000, 1), 1'b1);
        tick();
        weak_val_i = 1'b0;
        break_i    = 1'b1;
        tick();
        break_i = 1'b0;
        check("break_ready", longint'(weak_ready_o), 0);
        repeat (4) tick();
        check("break_idle_ready", longint'(weak_ready_o), 0);

        // Start and break together: break wins; a lone start then opens a clean stage.
        start_stage();
        drive_term(mk(0, 0, 0, 32'h70000, 0), 1'b1);
        tick();
        weak_val_i    = 1'b0;
        stage_start_i = 1'b1;
        break_i       = 1'b1;
        tick();
        break_i = 1'b0;
        check("start_break_ready", longint'(weak_ready_o), 0);
        tick();
        stage_start_i = 1'b0;
        check("restart_ready", longint'(weak_ready_o), 1);
        check("restart_sum", longint'(stage_sum_o), 0);
        check("restart_cnt", longint'(weak_cnt_o), 0);
        tq = {mk(32'h1, 32'h2, 32'h11000, 32'h0, 1)};
        run_terms(tq, 0);

        // Start during drain abandons the pending sum.
        start_stage();
        drive_term(mk(0, 0, 0, 32'h50000, 1), 1'b1);
        tick();
        weak_val_i    = 1'b0;
        stage_start_i = 1'b1;
        tick();
        stage_start_i = 1'b0;
        check("drain_restart_sum", longint'(stage_sum_o), 0);
        check("drain_restart_ready", longint'(weak_ready_o), 1);
        tq = {mk(0, 0, 0, 32'hFFFF0000, 0), mk(5, 9, 32'h3, 0, 1)};
        run_terms(tq, 0);

        // Reset mid-stage discards everything with no later pulse.
        start_stage();
        drive_term(mk(0, 0, 0, 32'h10000, 0), 1'b1);
        tick();
        drive_term(mk(0, 0, 0, 32'h10000, 0), 1'b1);
        tick();
        weak_val_i = 1'b0;
        rst_i      = 1'b1;
        tick();
        check("midrst_sum", longint'(stage_sum_o), 0);
        check("midrst_val", longint'(stage_sum_val_o), 0);
        check("midrst_ready", longint'(weak_ready_o), 0);
        check("midrst_cnt", longint'(weak_cnt_o), 0);
        check("midrst_err", longint'(error_o), 0);
        rst_i = 1'b0;
        repeat (5) tick();
        check("postrst_ready", longint'(weak_ready_o), 0);

        // Random stages with gaps, saturation in both directions and budget overruns.
        for (int s = 0; s < 40; s++) begin
            tq = {};
            n  = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                tq.push_back(rand_term((i == n - 1 && n < int'(MAX_WEAK)) || ($urandom_range(99) < 20)));
            end
            run_stage(tq, (s % 2 == 0) ? 0 : 30);
        end

        repeat (4) tick();
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
